contador32bits_checker: RTL and testbench

- Hardware self-checker attached to the output side of the 32-bit cascaded counter; it is the consumer of the counter's `Q`/`rco`/`load`.
- Runs a cycle-accurate reference model of the eight cascaded 4-bit stages from the same `enable`/`mode`/`D` stimulus.
- Compares the model against the counter's outputs every cycle and reports mismatches, error counts and first-failure cycle.
- Synthesised alongside the counter for gate-level / post-Qflow self-test.

---
 rtl/contador_pkg.sv | 18 +
 rtl/contador_modelo_nibble.sv | 61 ++++++
 rtl/contador32bits_checker.sv | 141 ++++++++++++++
 tb/tb_contador32bits_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared encodings for the 32-bit cascaded counter and its self-checker.
// Optional nibble diagnostics in the checker are enabled by CONTADOR_CHECKER_NIBBLE_DIAG_EN.
package contador_pkg;

    localparam int STAGE_W = 4;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

endpackage

// File: rtl/contador_modelo_nibble.sv
// One 4-bit reference stage of the cascaded counter model: registered nibble,
// combinational ripple-carry/borrow out.
module contador_modelo_nibble
    import contador_pkg::*;
#(
    parameter bit IS_LSB = 1'b1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               update,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] nibble,
    output logic               rco
);

    logic               carry;
    logic [STAGE_W-1:0] nibble_next;

    // Mode 10 subtracts 3 only in the LSB stage; upper stages just absorb the
    // borrow, so the whole chain behaves as a true N-bit minus-three.
    always_comb begin
        carry       = 1'b0;
        nibble_next = nibble;
        case (mode)
            MODE_UP: begin
                carry       = (nibble == 4'hF);
                nibble_next = nibble + 4'd1;
            end
            MODE_DOWN: begin
                carry       = (nibble == 4'h0);
                nibble_next = nibble - 4'd1;
            end
            MODE_DOWN3: begin
                if (IS_LSB) begin
                    carry       = (nibble < 4'd3);
                    nibble_next = nibble - 4'd3;
                end else begin
                    carry       = (nibble == 4'h0);
                    nibble_next = nibble - 4'd1;
                end
            end
            default: begin
                carry       = 1'b0;
                nibble_next = d;
            end
        endcase
        rco = enable && carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nibble <= '0;
        end else if (update && enable) begin
            nibble <= nibble_next;
        end
    end

endmodule

// File: rtl/contador32bits_checker.sv
// Cycle-accurate self-checker for the 32-bit cascaded counter.
// Define CONTADOR_CHECKER_NIBBLE_DIAG_EN to add per-nibble mismatch outputs.
module contador32bits_checker
    import contador_pkg::*;
#(
    parameter int N           = 32,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       D,
    input  logic [N-1:0]     dut_q,
    input  logic             dut_rco,
    input  logic             dut_load,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [1:0]       state
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
    ,
    output logic [N/STAGE_W-1:0] err_nibble_mask,
    output logic [N/STAGE_W-1:0] err_nibble_acc
`endif
);

    localparam int STAGES = N / STAGE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t         state_r;
    logic           update;
    logic [N-1:0]   model_q;
    logic           exp_rco;
    logic           exp_load;
    logic           mismatch;

    assign update = (state_r != ST_HALT);
    assign state  = state_r;

    // Loads reach every stage directly; counting enables ripple through the rco chain.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic en;
        logic rco;

        if (k == 0) begin : g_lsb
            assign en = enable;
        end else begin : g_upper
            assign en = (mode == MODE_LOAD) ? enable : g_stage[k-1].rco;
        end

        contador_modelo_nibble #(
            .IS_LSB (k == 0)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .update (update),
            .enable (en),
            .mode   (mode),
            .d      (D),
            .nibble (model_q[k*STAGE_W +: STAGE_W]),
            .rco    (rco)
        );
    end

    always_comb begin
        exp_rco  = g_stage[STAGES-1].rco;
        exp_load = (mode == MODE_LOAD) && enable;
        mismatch = (dut_q != model_q) || (dut_rco != exp_rco) || (dut_load != exp_load);
    end

    // first_err_cycle latches the pre-increment cycle_count of the first bad cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            err_pulse       <= 1'b0;
            err_sticky      <= 1'b0;
            err_count       <= '0;
            cycle_count     <= '0;
            first_err_cycle <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r   <= ST_CHECK;
                    err_pulse <= 1'b0;
                end
                ST_CHECK: begin
                    err_pulse <= mismatch;
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_ONE;
                    end
                    if (mismatch) begin
                        if (err_count != CNT_MAX) begin
                            err_count <= err_count + CNT_ONE;
                        end
                        if (!err_sticky) begin
                            first_err_cycle <= cycle_count;
                        end
                        err_sticky <= 1'b1;
                        if (STOP_ON_ERR) begin
                            state_r <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    err_pulse <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    err_pulse <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
    logic [STAGES-1:0] nibble_diff;

    for (genvar j = 0; j < STAGES; j++) begin : g_diff
        assign nibble_diff[j] = (dut_q[j*STAGE_W +: STAGE_W] != model_q[j*STAGE_W +: STAGE_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_nibble_mask <= '0;
            err_nibble_acc  <= '0;
        end else if (state_r == ST_CHECK) begin
            err_nibble_mask <= nibble_diff;
            err_nibble_acc  <= err_nibble_acc | nibble_diff;
        end else begin
            err_nibble_mask <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_contador32bits_checker.sv
// Scoreboard bench: a behavioural counter feeds two checkers (free-running and
// stop-on-error) with optional fault injection on q, rco or load.
module tb_contador32bits_checker;

    localparam int N     = 32;
    localparam int CNT_W = 16;
    localparam int NS    = N / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [3:0]       D;
    logic [N-1:0]     dut_q;
    logic             dut_rco;
    logic             dut_load;

    logic             a_pulse, a_sticky, h_pulse, h_sticky;
    logic [CNT_W-1:0] a_cnt, a_cyc, a_first, h_cnt, h_cyc, h_first;
    logic [1:0]       a_state, h_state;
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
    logic [NS-1:0]    a_mask, a_acc, h_mask, h_acc;
`endif

    typedef struct packed {
        logic [1:0]  st;
        logic        pulse;
        logic        sticky;
        logic [15:0] cnt;
        logic [15:0] cyc;
        logic [15:0] first;
        logic [7:0]  mask;
        logic [7:0]  acc;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t h;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    exp_t        ea, eh;
    logic [31:0] cnt_ref;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    contador32bits_checker #(.N(N), .CNT_W(CNT_W), .STOP_ON_ERR(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .dut_q(dut_q), .dut_rco(dut_rco), .dut_load(dut_load),
        .err_pulse(a_pulse), .err_sticky(a_sticky), .err_count(a_cnt),
        .cycle_count(a_cyc), .first_err_cycle(a_first), .state(a_state)
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
        , .err_nibble_mask(a_mask), .err_nibble_acc(a_acc)
`endif
    );

    contador32bits_checker #(.N(N), .CNT_W(CNT_W), .STOP_ON_ERR(1'b1)) dut_halt (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .dut_q(dut_q), .dut_rco(dut_rco), .dut_load(dut_load),
        .err_pulse(h_pulse), .err_sticky(h_sticky), .err_count(h_cnt),
        .cycle_count(h_cyc), .first_err_cycle(h_first), .state(h_state)
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
        , .err_nibble_mask(h_mask), .err_nibble_acc(h_acc)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Fault codes: 1 = flip q bit 20 (nibble 5), 2 = flip rco, 3 = flip load.
    function automatic exp_t stepExp(input exp_t e, input logic rst, input int fault, input bit stop);
        exp_t n;
        n = e;
        if (rst) begin
            n = '0;
        end else begin
            case (e.st)
                2'd0: n.st = 2'd1;
                2'd1: begin
                    n.pulse = (fault != 0);
                    n.mask  = (fault == 1) ? 8'h20 : 8'h00;
                    n.acc   = e.acc | n.mask;
                    n.cyc   = (e.cyc == 16'hFFFF) ? e.cyc : e.cyc + 16'd1;
                    if (fault != 0) begin
                        n.cnt    = (e.cnt == 16'hFFFF) ? e.cnt : e.cnt + 16'd1;
                        n.first  = e.sticky ? e.first : e.cyc;
                        n.sticky = 1'b1;
                        if (stop) n.st = 2'd2;
                    end
                end
                default: begin
                    n.pulse = 1'b0;
                    n.mask  = 8'h00;
                end
            endcase
        end
        return n;
    endfunction

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] md,
                                 input logic [3:0] dd, input int fault);
        logic rco_ref;
        logic load_ref;
        reset    = rst;
        enable   = en;
        mode     = md;
        D        = dd;
        load_ref = (md == 2'b11) && en;
        rco_ref  = en && ((md == 2'b00 && cnt_ref == 32'hFFFF_FFFF) ||
                          (md == 2'b01 && cnt_ref == 32'h0) ||
                          (md == 2'b10 && cnt_ref < 32'd3));
        dut_q    = cnt_ref ^ ((fault == 1) ? 32'h0010_0000 : 32'h0);
        dut_rco  = rco_ref ^ (fault == 2);
        dut_load = load_ref ^ (fault == 3);
        ea = stepExp(ea, rst, fault, 1'b0);
        eh = stepExp(eh, rst, fault, 1'b1);
        sb_q.push_back({ea, eh});
        if (rst) cnt_ref = 32'h0;
        else if (en) begin
            case (md)
                2'b00:   cnt_ref = cnt_ref + 32'd1;
                2'b01:   cnt_ref = cnt_ref - 32'd1;
                2'b10:   cnt_ref = cnt_ref - 32'd3;
                default: cnt_ref = {8{dd}};
            endcase
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("a.state",  a_state,  mon_e.a.st);
            checkOutput("a.pulse",  a_pulse,  mon_e.a.pulse);
            checkOutput("a.sticky", a_sticky, mon_e.a.sticky);
            checkOutput("a.count",  a_cnt,    mon_e.a.cnt);
            checkOutput("a.cycle",  a_cyc,    mon_e.a.cyc);
            checkOutput("a.first",  a_first,  mon_e.a.first);
            checkOutput("h.state",  h_state,  mon_e.h.st);
            checkOutput("h.pulse",  h_pulse,  mon_e.h.pulse);
            checkOutput("h.sticky", h_sticky, mon_e.h.sticky);
            checkOutput("h.count",  h_cnt,    mon_e.h.cnt);
            checkOutput("h.cycle",  h_cyc,    mon_e.h.cyc);
            checkOutput("h.first",  h_first,  mon_e.h.first);
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
            checkOutput("a.mask", a_mask, mon_e.a.mask);
            checkOutput("a.acc",  a_acc,  mon_e.a.acc);
            checkOutput("h.mask", h_mask, mon_e.h.mask);
            checkOutput("h.acc",  h_acc,  mon_e.h.acc);
`endif
        end
    end

    initial begin
        cnt_ref = 32'h0;
        ea      = '0;
        eh      = '0;
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 4'h0, 0);

        applyStimulus(1'b0, 1'b1, 2'b11, 4'hA, 0);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'hF, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'h0, 0);
        checkOutput("cycle_count after up-wrap", a_cyc, 32'd2);
        checkOutput("err_count after up-wrap", a_cnt, 32'd0);

        applyStimulus(1'b0, 1'b1, 2'b11, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'h0, 1);
        checkOutput("err_pulse after q fault", a_pulse, 32'd1);
        checkOutput("err_sticky after q fault", a_sticky, 32'd1);
        checkOutput("first_err_cycle", a_first, 32'd5);
        checkOutput("err_count after q fault", a_cnt, 32'd1);
        checkOutput("halt instance state", h_state, 32'd2);
`ifdef CONTADOR_CHECKER_NIBBLE_DIAG_EN
        checkOutput("err_nibble_mask", a_mask, 32'h20);
`endif

        applyStimulus(1'b0, 1'b1, 2'b11, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 2);
        applyStimulus(1'b0, 1'b0, 2'b11, 4'h3, 3);
        applyStimulus(1'b0, 1'b1, 2'b10, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 4'h0, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 4'h0, 0);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'h5, 0);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'h0, 0);
        checkOutput("halt frozen state", h_state, 32'd2);
        checkOutput("halt frozen cycle_count", h_cyc, 32'd6);
        checkOutput("halt frozen err_count", h_cnt, 32'd1);
        checkOutput("halt err_pulse low", h_pulse, 32'd0);
        checkOutput("err_count after three faults", a_cnt, 32'd3);
        checkOutput("first_err_cycle unchanged", a_first, 32'd5);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 0);
        end
        checkOutput("err_count after enable=0 hold", a_cnt, 32'd3);

        applyStimulus(1'b1, 1'b1, 2'b00, 4'h0, 0);
        checkOutput("halt state after reset", h_state, 32'd0);
        checkOutput("halt err_count after reset", h_cnt, 32'd0);
        checkOutput("halt sticky after reset", h_sticky, 32'd0);
        checkOutput("err_count after reset", a_cnt, 32'd0);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 0);
        end
        checkOutput("sweep err_count", a_cnt, 32'd0);
        checkOutput("sweep halt state", h_state, 32'd1);
        checkOutput("sweep cycle_count", a_cyc, 32'd299);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
